// File: rtl/register_bank.sv
// Register bank with per-entry valid bits, registered 1-cycle reads and a live entry count.
// Define REGISTER_BANK_BYPASS_EN for write-first same-address collisions; the default is read-first.
module register_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             w_en,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] d,
   input  logic             r_en,
   input  logic [AW-1:0]    r_addr,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             q_hit,
   output logic [AW:0]      num_valid,
   output logic             full
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW:0]      cnt;
   logic             wr_fire;
   logic             new_entry;
   logic             bypass_hit;
   logic [WIDTH-1:0] rd_data;
   logic             rd_hit;

   // clr wins over a concurrent write; the write is simply dropped.
   assign wr_fire   = w_en & ~clr;
   assign new_entry = wr_fire & ~vld[w_addr];

`ifdef REGISTER_BANK_BYPASS_EN
   assign bypass_hit = wr_fire && (w_addr == r_addr);
`else
   assign bypass_hit = 1'b0;
`endif

   // Reads sample pre-edge state, so a read alongside clr sees the old contents.
   assign rd_data = bypass_hit ? d : mem[r_addr];
   assign rd_hit  = bypass_hit | vld[r_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         vld <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         vld <= '0;
      end else if (wr_fire) begin
         mem[w_addr] <= d;
         vld[w_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (new_entry && (cnt != FULL_CNT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Read port: r_en at an edge presents q/q_hit after that edge with a single-cycle
   // q_valid pulse; there is no backpressure, and q/q_hit hold while r_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         q_hit   <= 1'b0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= r_en;
         if (r_en) begin
            q     <= rd_data;
            q_hit <= rd_hit;
         end
      end
   end

   assign num_valid = cnt;
   assign full      = (cnt == FULL_CNT);

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: randomized and directed traffic against an array-based model.
module tb_register_bank;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             w_en;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] d;
   logic             r_en;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             q_hit;
   logic [AW:0]      num_valid;
   logic             full;

   register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_addr(w_addr), .d(d),
      .r_en(r_en), .r_addr(r_addr), .q(q), .q_valid(q_valid), .q_hit(q_hit),
      .num_valid(num_valid), .full(full)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: stored words, written flags, last read result
   logic [WIDTH-1:0] m_data [DEPTH];
   logic             m_written [DEPTH];
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   last_rd;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (m_written[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_data[i]    = '0;
         m_written[i] = 1'b0;
      end
      exp_q.delete();
      last_rd = '0;
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // driver: called at a negedge, applies one cycle of inputs, returns at the next negedge
   task automatic issue(input logic c, input logic we, input int wa, input int wd,
                        input logic re, input int ra);
      logic [WIDTH:0] e;
      clr = c; w_en = we; w_addr = AW'(wa); d = WIDTH'(wd); r_en = re; r_addr = AW'(ra);
      if (re) begin
         e = {m_written[ra], m_data[ra]};
`ifdef REGISTER_BANK_BYPASS_EN
         if (we && !c && wa == ra) e = {1'b1, WIDTH'(wd)};
`endif
         exp_q.push_back(e);
      end
      if (c) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_written[i] = 1'b0;
         end
      end else if (we) begin
         m_data[wa]    = WIDTH'(wd);
         m_written[wa] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 0, 0, 1'b0, 0);
   endtask

   // monitor: samples 1 time unit after each rising edge
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         logic [WIDTH:0] e;
         int n;
         n = model_count();
         check("num_valid", int'(num_valid), n);
         check("full", int'(full), int'(n == DEPTH));
         if (q_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL q_valid: got unexpected pulse, expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               last_rd = e;
               check("q", int'(q), int'(e[WIDTH-1:0]));
               check("q_hit", int'(q_hit), int'(e[WIDTH]));
            end
         end else begin
            check("q_valid_missing", int'(exp_q.size()), 0);
            check("q_hold", int'(q), int'(last_rd[WIDTH-1:0]));
            check("q_hit_hold", int'(q_hit), int'(last_rd[WIDTH]));
         end
      end
   end

   initial begin
      clr = 0; w_en = 0; w_addr = '0; d = '0; r_en = 0; r_addr = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_q", int'(q), 0);
      check("rst_q_valid", int'(q_valid), 0);
      check("rst_num_valid", int'(num_valid), 0);
      check("rst_full", int'(full), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // read of never-written entry
      issue(0, 0, 0, 0, 1, 2);
      idle();
      // writes, reads, rewrite
      issue(0, 1, 1, 'hA5, 0, 0);
      issue(0, 1, 3, 'h3C, 0, 0);
      issue(0, 0, 0, 0, 1, 1);
      issue(0, 0, 0, 0, 1, 3);
      issue(0, 1, 1, 'h11, 0, 0);
      idle();
      // fill, then rewrite at full
      issue(0, 1, 0, 'h01, 0, 0);
      issue(0, 1, 2, 'h10, 0, 0);
      issue(0, 1, 0, 'h77, 0, 0);
      issue(0, 0, 0, 0, 1, 0);
      // same-address collision, then follow-up read
      issue(0, 1, 2, 'h5A, 1, 2);
      issue(0, 0, 0, 0, 1, 2);
      // write and read to different addresses together
      issue(0, 1, 3, 'hC3, 1, 1);
      // clr with concurrent write and read
      issue(0, 1, 0, 'h22, 0, 0);
      issue(1, 1, 0, 'hFF, 1, 0);
      issue(0, 0, 0, 0, 1, 0);
      idle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         issue(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
               $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
               $urandom_range(0, 1), $urandom_range(0, DEPTH - 1));
      end
      idle();

      // reset mid-cycle with a read in flight
      for (int i = 0; i < DEPTH; i++) issue(0, 1, i, 'h40 + i, 0, 0);
      clr = 0; w_en = 0; r_en = 1; r_addr = AW'(1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_q", int'(q), 0);
      check("arst_q_valid", int'(q_valid), 0);
      check("arst_q_hit", int'(q_hit), 0);
      check("arst_num_valid", int'(num_valid), 0);
      check("arst_full", int'(full), 0);
      model_reset();
      r_en = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      for (int i = 0; i < DEPTH; i++) issue(0, 0, 0, 0, 1, i);
      idle();
      idle();
      check("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 4, number of registers (power of two, >=2); AW = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clr  input  1  synchronous clear-all command.
REQ-006 w_en  input  1  write enable.
REQ-007 w_addr  input  AW  write address.
REQ-008 d  input  WIDTH  write data.
REQ-009 r_en  input  1  read request.
REQ-010 r_addr  input  AW  read address.
REQ-011 q  output  WIDTH  registered read data.
REQ-012 q_valid  output  1  one-cycle pulse, q updated this cycle.
REQ-013 q_hit  output  1  entry read was written since last clear/reset; qualified by q_valid.
REQ-014 num_valid  output  AW+1  count of entries written since last clear/reset.
REQ-015 full  output  1  num_valid == DEPTH.

Function
REQ-016 Write: w_en=1 and clr=0 at an edge SHALL store d into entry w_addr and set its valid bit.
REQ-017 Read latency SHALL be exactly 1 cycle: r_en at edge N -> q, q_hit, q_valid=1 after edge N.
REQ-018 When r_en=0, q and q_hit SHALL hold their previous values and q_valid SHALL be 0.
REQ-019 num_valid SHALL increment by 1 only on a write to an entry whose valid bit is 0; rewrites of a valid entry SHALL leave it unchanged.
REQ-020 num_valid SHALL never exceed DEPTH; at full, writes still update data and num_valid stays DEPTH.
REQ-021 clr=1 SHALL zero all entries, all valid bits and num_valid at that edge; a concurrent write SHALL be dropped (clr has priority).
REQ-022 A read concurrent with clr SHALL return the pre-clear contents and valid bit of r_addr.
REQ-023 Reads of never-written entries SHALL return q=0, q_hit=0.
REQ-024 Simultaneous write and read to different addresses SHALL both complete with no interaction.
REQ-025 full SHALL be combinational from num_valid.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) set all entries, valid bits, q, q_hit, q_valid and num_valid to 0.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight read; q_valid SHALL be 0 on the first edge after rst_n deasserts unless r_en is sampled 1 at that edge.

Configuration
REQ-028 Macro REGISTER_BANK_BYPASS_EN SHALL select same-address read/write collision behaviour.
REQ-029 With REGISTER_BANK_BYPASS_EN defined: read and write (clr=0) to the same address at one edge SHALL return the new d with q_hit=1 (write-first).
REQ-030 Without it: the same collision SHALL return the old stored value and old valid bit (read-first); the write still completes.
REQ-031 The macro SHALL NOT affect any other behaviour, including clr priority (REQ-021/022).

Verification (WIDTH=8, DEPTH=4)
REQ-032 Reset then r_en addr 2 -> next cycle q=0x00, q_hit=0, q_valid=1, num_valid=0.
REQ-033 Write 0xA5@1, 0x3C@3, then read 1 and 3 -> q=0xA5 then 0x3C, q_hit=1, num_valid=2; rewrite 0x11@1 -> num_valid stays 2.
REQ-034 Write all 4 addresses then 0x77@0 -> full=1, num_valid=4, read 0 returns 0x77.
REQ-035 Same edge write 0x5A@2 and read 2 (entry held 0x10) -> q=0x5A with macro, q=0x10 without; following read of 2 returns 0x5A in both builds.
REQ-036 Same edge clr and write 0xFF@0 with read 0 (held 0x22) -> q=0x22, q_hit=1; afterwards read 0 -> 0x00, q_hit=0, num_valid=0.
REQ-037 Drop rst_n mid-cycle after r_en issued with entries loaded -> q, q_valid, num_valid 0 immediately; subsequent reads return 0.
